// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command, response and APB bus signals of the APB master bridge
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic                          cmd_write;
  logic [ADDR_WIDTH-1:0]         cmd_addr;
  logic [DATA_WIDTH-1:0]         cmd_wdata;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic                          rsp_write;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_timeout;
  logic                          PSEL;
  logic                          PENABLE;
  logic                          PWRITE;
  logic [ADDR_WIDTH-1:0]         PADDR;
  logic [DATA_WIDTH-1:0]         PWDATA;
  logic [DATA_WIDTH-1:0]         PRDATA;
  logic                          PREADY;
  logic                          busy;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    output cmd_ready, fifo_count, rsp_valid, rsp_write, rsp_rdata, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    input  cmd_ready, fifo_count, rsp_valid, rsp_write, rsp_rdata, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy
  );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: buffered command port driving an APB master sequence with wait-state timeout
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic PCLK,
  input logic PRESET,
  apb_master_bridge_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t          state;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [AW:0]     count;
  logic [TW-1:0]   tcnt;
  logic            rdy_en, full, push, pop, tmo;
  logic [EW-1:0]   head;
  assign full           = count == (AW+1)'(FIFO_DEPTH);
  assign bus.cmd_ready  = rdy_en & ~full;
  assign push           = bus.cmd_valid & bus.cmd_ready;
  assign pop            = state == IDLE && count != '0 && !bus.rsp_valid;
  assign head           = mem[rp];
  assign tmo            = TIMEOUT_CYCLES != 0 && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign bus.fifo_count = count;
  assign bus.busy       = state != IDLE || count != '0;
  // command storage, written only on an accepted push
  always_ff @(posedge PCLK)
    if (push) mem[wp] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
  // FIFO pointers and occupancy; cmd_ready is held low until the first edge after reset
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      wp     <= '0;
      rp     <= '0;
      count  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      wp     <= push ? wp + 1'b1 : wp;
      rp     <= pop ? rp + 1'b1 : rp;
      count  <= push && !pop ? count + 1'b1 : !push && pop ? count - 1'b1 : count;
    end
  // APB sequencer with registered bus and response outputs
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      state           <= IDLE;
      tcnt            <= '0;
      bus.PSEL        <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= '0;
      bus.PWDATA      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_write   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          bus.PSEL   <= 1'b1;
          bus.PWRITE <= head[EW-1];
          bus.PADDR  <= head[EW-2 -: ADDR_WIDTH];
          bus.PWDATA <= head[EW-1] ? head[DATA_WIDTH-1:0] : '0;
          state      <= SETUP;
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: if (bus.PREADY || tmo) begin
          bus.rsp_valid   <= 1'b1;
          bus.rsp_write   <= bus.PWRITE;
          bus.rsp_rdata   <= bus.PREADY && !bus.PWRITE ? bus.PRDATA : '0;
          bus.rsp_timeout <= !bus.PREADY;
          bus.PSEL        <= 1'b0;
          bus.PENABLE     <= 1'b0;
          tcnt            <= '0;
          state           <= IDLE;
        end else tcnt <= tcnt + 1'b1;
        default: begin
          bus.PSEL    <= 1'b0;
          bus.PENABLE <= 1'b0;
          tcnt        <= '0;
          state       <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed scenarios against an APB memory model with controllable PREADY
module tb_apb_master_bridge;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  int checks = 0;
  int errors = 0;
  logic        stuck = 1'b0;
  int          wait_n = 0;
  int          acc_cnt = 0;
  logic [31:0] mem [1024] = '{default: 32'h0};
  apb_master_bridge_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .FIFO_DEPTH(4)) bus ();
  apb_master_bridge #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8))
    dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus));
  always #5 PCLK = ~PCLK;
  assign bus.PREADY = !stuck && acc_cnt >= wait_n;
  assign bus.PRDATA = bus.PREADY ? mem[bus.PADDR] : 32'hDEAD_BEEF;
  // slave model: counts wait cycles in ACCESS and stores completed writes
  always @(posedge PCLK) begin
    if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
    else if (!(bus.PSEL && bus.PENABLE)) acc_cnt <= 0;
    if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) mem[bus.PADDR] <= bus.PWDATA;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end
  task automatic push(input logic w, input logic [9:0] a, input logic [31:0] d);
    int n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_rsp(input string name);
    int n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(negedge PCLK);
      n++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_rsp_wait: rsp_valid=%b required 1", name, bus.rsp_valid);
    end
  endtask
  task automatic consume;
    bus.rsp_ready = 1'b1;
    @(negedge PCLK);
    bus.rsp_ready = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge PCLK);
    checks++;
    if ({bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready/psel/pen/rsp/busy=%b required 00000",
               {bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.busy});
    end
    checks++;
    if (bus.fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_count: fifo_count=%0d required 0", bus.fifo_count);
    end
    PRESET = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_pre_edge: cmd_ready=%b required 0", bus.cmd_ready);
    end
    @(negedge PCLK);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_post_edge: cmd_ready=%b required 1", bus.cmd_ready);
    end
  endtask
  task automatic test_write_read;
    push(1'b1, 10'h010, 32'h0000_00A5);
    checks++;
    if ({bus.PSEL, bus.fifo_count, bus.busy} !== {1'b0, 3'd1, 1'b1}) begin
      errors++;
      $display("FAIL wr_accept: psel/count/busy=%b required 0_001_1", {bus.PSEL, bus.fifo_count, bus.busy});
    end
    @(negedge PCLK);
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.fifo_count} !==
        {3'b101, 10'h010, 32'h0000_00A5, 3'd0}) begin
      errors++;
      $display("FAIL wr_setup: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h count=%0d required 1 0 1 010 000000a5 0",
               bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.fifo_count);
    end
    @(negedge PCLK);
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL wr_access: psel/pen/rsp=%b required 110", {bus.PSEL, bus.PENABLE, bus.rsp_valid});
    end
    @(negedge PCLK);
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.rsp_write, bus.rsp_timeout, bus.rsp_rdata} !==
        {5'b00110, 32'h0}) begin
      errors++;
      $display("FAIL wr_rsp: psel/pen/valid/write/tmo=%b rdata=%h required 00110 00000000",
               {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.rsp_write, bus.rsp_timeout}, bus.rsp_rdata);
    end
    consume;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_consume: rsp_valid=%b required 0", bus.rsp_valid);
    end
    push(1'b0, 10'h010, 32'hFFFF_FFFF);
    @(negedge PCLK);
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== {3'b100, 10'h010, 32'h0}) begin
      errors++;
      $display("FAIL rd_setup: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h required 1 0 0 010 00000000",
               bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA);
    end
    repeat (2) @(negedge PCLK);
    checks++;
    if ({bus.rsp_valid, bus.rsp_write, bus.rsp_timeout, bus.rsp_rdata} !== {3'b100, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL rd_rsp: valid/write/tmo=%b rdata=%h required 100 000000a5",
               {bus.rsp_valid, bus.rsp_write, bus.rsp_timeout}, bus.rsp_rdata);
    end
    consume;
  endtask
  task automatic test_fifo_full;
    logic ok = 1'b1;
    for (int i = 0; i < 5; i++) push(1'b1, 10'(10'h100 + i), 32'h1000 + i);
    checks++;
    if ({bus.fifo_count, bus.cmd_ready, bus.rsp_valid} !== {3'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL full_state: count=%0d ready=%b rsp_valid=%b required 4 0 1",
               bus.fifo_count, bus.cmd_ready, bus.rsp_valid);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 10'h105;
    bus.cmd_wdata = 32'h0000_0BAD;
    repeat (3) @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.fifo_count, bus.cmd_ready, bus.PSEL} !== {3'd4, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL full_refuse: count=%0d ready=%b psel=%b required 4 0 0",
               bus.fifo_count, bus.cmd_ready, bus.PSEL);
    end
    for (int i = 0; i < 5; i++) begin
      wait_rsp("drain");
      checks++;
      if ({bus.rsp_write, bus.rsp_timeout} !== 2'b10) begin
        errors++;
        $display("FAIL drain_rsp%0d: write/tmo=%b required 10", i, {bus.rsp_write, bus.rsp_timeout});
      end
      consume;
    end
    for (int i = 0; i < 5; i++) if (mem[10'h100 + i] !== 32'h1000 + i) ok = 1'b0;
    checks++;
    if (!ok || mem[10'h105] !== 32'h0) begin
      errors++;
      $display("FAIL full_mem: writes_ok=%b mem[105]=%h required 1 00000000", ok, mem[10'h105]);
    end
    repeat (4) @(negedge PCLK);
    checks++;
    if ({bus.rsp_valid, bus.busy, bus.fifo_count} !== {2'b00, 3'd0}) begin
      errors++;
      $display("FAIL full_idle: rsp_valid=%b busy=%b count=%0d required 0 0 0",
               bus.rsp_valid, bus.busy, bus.fifo_count);
    end
  endtask
  task automatic test_wait_states;
    logic ok = 1'b1;
    wait_n = 3;
    push(1'b0, 10'h010, 32'h0);
    @(negedge PCLK);
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      if ({bus.PSEL, bus.PENABLE, bus.PADDR, bus.rsp_valid} !== {2'b11, 10'h010, 1'b0}) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ws_hold: access phase not stable for 4 cycles, ok=%b required 1", ok);
    end
    @(negedge PCLK);
    checks++;
    if ({bus.PSEL, bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata} !== {3'b010, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL ws_rsp: psel/valid/tmo=%b rdata=%h required 010 000000a5",
               {bus.PSEL, bus.rsp_valid, bus.rsp_timeout}, bus.rsp_rdata);
    end
    consume;
    wait_n = 0;
  endtask
  task automatic test_timeout;
    int n = 0;
    stuck = 1'b1;
    push(1'b0, 10'h010, 32'h0);
    for (int i = 0; i < 30 && !bus.rsp_valid; i++) begin
      if (bus.PSEL && bus.PENABLE) n++;
      @(negedge PCLK);
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL tmo_cycles: access cycles=%0d required 8", n);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_write, bus.rsp_timeout, bus.rsp_rdata, bus.PSEL} !== {3'b101, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL tmo_rsp: valid/write/tmo=%b rdata=%h psel=%b required 101 00000000 0",
               {bus.rsp_valid, bus.rsp_write, bus.rsp_timeout}, bus.rsp_rdata, bus.PSEL);
    end
    stuck = 1'b0;
    push(1'b1, 10'h020, 32'h0000_005A);
    consume;
    wait_rsp("tmo_next");
    checks++;
    if ({bus.rsp_write, bus.rsp_timeout, mem[10'h020]} !== {2'b10, 32'h0000_005A}) begin
      errors++;
      $display("FAIL tmo_next: write/tmo=%b mem[020]=%h required 10 0000005a",
               {bus.rsp_write, bus.rsp_timeout}, mem[10'h020]);
    end
    consume;
  endtask
  task automatic test_back_to_back;
    logic seen = 1'b0;
    push(1'b0, 10'h010, 32'h0);
    push(1'b0, 10'h104, 32'h0);
    wait_rsp("bp_first");
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      if (bus.PSEL) seen = 1'b1;
    end
    checks++;
    if ({seen, bus.fifo_count, bus.rsp_rdata} !== {1'b0, 3'd1, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL bp_hold: psel_seen=%b count=%0d rdata=%h required 0 1 000000a5",
               seen, bus.fifo_count, bus.rsp_rdata);
    end
    consume;
    checks++;
    if ({bus.rsp_valid, bus.PSEL} !== 2'b00) begin
      errors++;
      $display("FAIL bp_gap: rsp_valid/psel=%b required 00", {bus.rsp_valid, bus.PSEL});
    end
    @(negedge PCLK);
    checks++;
    if ({bus.PSEL, bus.PADDR} !== {1'b1, 10'h104}) begin
      errors++;
      $display("FAIL bp_next: psel=%b paddr=%h required 1 104", bus.PSEL, bus.PADDR);
    end
    wait_rsp("bp_second");
    checks++;
    if (bus.rsp_rdata !== 32'h0000_1004) begin
      errors++;
      $display("FAIL bp_rdata: rsp_rdata=%h required 00001004", bus.rsp_rdata);
    end
    consume;
  endtask
  task automatic test_reset_mid;
    logic seen = 1'b0;
    int n = 0;
    stuck = 1'b1;
    push(1'b0, 10'h010, 32'h0);
    push(1'b0, 10'h104, 32'h0);
    while (!(bus.PSEL && bus.PENABLE) && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    #1 PRESET = 1'b1;
    #1;
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.busy, bus.fifo_count} !== {4'b0000, 3'd0}) begin
      errors++;
      $display("FAIL rst_async: psel/pen/ready/busy=%b count=%0d required 0000 0",
               {bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.busy}, bus.fifo_count);
    end
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    stuck = 1'b0;
    repeat (5) begin
      @(negedge PCLK);
      if (bus.rsp_valid || bus.PSEL) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_rsp: activity_seen=%b required 0", seen);
    end
    push(1'b1, 10'h030, 32'h0000_0077);
    wait_rsp("rst_after");
    checks++;
    if ({bus.rsp_write, bus.rsp_timeout, mem[10'h030]} !== {2'b10, 32'h0000_0077}) begin
      errors++;
      $display("FAIL rst_after: write/tmo=%b mem[030]=%h required 10 00000077",
               {bus.rsp_write, bus.rsp_timeout}, mem[10'h030]);
    end
    consume;
    @(negedge PCLK);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_final_busy: busy=%b required 0", bus.busy);
    end
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    test_reset;
    test_write_read;
    test_fifo_full;
    test_wait_states;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
